// File: rtl/bsg_cgol_row.sv
// ============================================================================
// bsg_cgol_row : one row of life-like cells with programmable B/S rule masks.
// Optional per-cell age counters under BSG_CGOL_AGE_EN.           Rev 1.0
// ============================================================================
`default_nettype none

module bsg_cgol_row #(
  parameter int width_p     = 8,
  parameter int gen_width_p = 16,
  parameter int wrap_p      = 0,
  parameter int age_width_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             en_i,
  input  logic [width_p-1:0]               north_i,
  input  logic [width_p-1:0]               south_i,
  input  logic [8:0]                       birth_mask_i,
  input  logic [8:0]                       survive_mask_i,
  input  logic                             update_i,
  input  logic [width_p-1:0]               update_val_i,
  output logic [width_p-1:0]               data_o,
  output logic [gen_width_p-1:0]           gen_o,
  output logic                             stable_o,
  output logic [width_p*age_width_p-1:0]   age_o
);

  logic [width_p-1:0]     data_q, data_d;
  logic [gen_width_p-1:0] gen_q, gen_d;
  logic                   stable_q, stable_d;

  // Rows padded by one cell at each end: index 0 is column -1, index width_p+1 is column width_p.
  logic [width_p+1:0] n_ext_w, s_ext_w, r_ext_w;
  logic [width_p-1:0] step_row_w;
  logic [3:0]         cnt_w [width_p];

  generate
    if (wrap_p != 0) begin : g_wrap
      assign n_ext_w = {north_i[0], north_i, north_i[width_p-1]};
      assign s_ext_w = {south_i[0], south_i, south_i[width_p-1]};
      assign r_ext_w = {data_q[0],  data_q,  data_q[width_p-1]};
    end else begin : g_dead
      assign n_ext_w = {1'b0, north_i, 1'b0};
      assign s_ext_w = {1'b0, south_i, 1'b0};
      assign r_ext_w = {1'b0, data_q,  1'b0};
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < width_p; i++) begin
      cnt_w[i] = {3'b000, n_ext_w[i]} + {3'b000, n_ext_w[i+1]} + {3'b000, n_ext_w[i+2]}
               + {3'b000, s_ext_w[i]} + {3'b000, s_ext_w[i+1]} + {3'b000, s_ext_w[i+2]}
               + {3'b000, r_ext_w[i]} + {3'b000, r_ext_w[i+2]};
      step_row_w[i] = data_q[i] ? survive_mask_i[cnt_w[i]] : birth_mask_i[cnt_w[i]];
    end
  end

  // A step outranks a load arriving in the same cycle.
  always_comb begin
    data_d   = data_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    if (en_i) begin
      data_d   = step_row_w;
      gen_d    = gen_q + 1'b1;
      stable_d = (step_row_w == data_q);
    end else if (update_i) begin
      data_d   = update_val_i;
      gen_d    = '0;
      stable_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q   <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
    end
  end

  assign data_o   = data_q;
  assign gen_o    = gen_q;
  assign stable_o = stable_q;

`ifdef BSG_CGOL_AGE_EN
  localparam logic [age_width_p-1:0] c_age_max = '1;

  logic [width_p*age_width_p-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (en_i) begin
      for (int i = 0; i < width_p; i++) begin
        if (!step_row_w[i])
          age_d[i*age_width_p +: age_width_p] = '0;
        else if (age_q[i*age_width_p +: age_width_p] != c_age_max)
          age_d[i*age_width_p +: age_width_p] = age_q[i*age_width_p +: age_width_p] + 1'b1;
      end
    end else if (update_i) begin
      age_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) age_q <= '0;
    else         age_q <= age_d;
  end

  assign age_o = age_q;
`else
  assign age_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_cgol_row.sv
// ============================================================================
// tb_bsg_cgol_row : directed-vector bench for bsg_cgol_row (dead, wrap, 2-bit gen,
// 2-bit age instances sharing one stimulus).                        Rev 1.0
// ============================================================================
`default_nettype none

module tb_bsg_cgol_row;

  logic       clk = 1'b0;
  logic       rst, en, upd;
  logic [7:0] north, south, uval;
  logic [8:0] bm, sm;

  logic [7:0]  d0, d1, d2, d3;
  logic [15:0] g0, g1, g3;
  logic [1:0]  g2;
  logic        s0, s1, s2, s3;
  logic [31:0] a0, a1, a2;
  logic [15:0] a3;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bsg_cgol_row #(.width_p(8), .gen_width_p(16), .wrap_p(0), .age_width_p(4)) u_dead (
    .clk_i(clk), .reset_i(rst), .en_i(en), .north_i(north), .south_i(south),
    .birth_mask_i(bm), .survive_mask_i(sm), .update_i(upd), .update_val_i(uval),
    .data_o(d0), .gen_o(g0), .stable_o(s0), .age_o(a0));

  bsg_cgol_row #(.width_p(8), .gen_width_p(16), .wrap_p(1), .age_width_p(4)) u_wrap (
    .clk_i(clk), .reset_i(rst), .en_i(en), .north_i(north), .south_i(south),
    .birth_mask_i(bm), .survive_mask_i(sm), .update_i(upd), .update_val_i(uval),
    .data_o(d1), .gen_o(g1), .stable_o(s1), .age_o(a1));

  bsg_cgol_row #(.width_p(8), .gen_width_p(2), .wrap_p(0), .age_width_p(4)) u_gen2 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .north_i(north), .south_i(south),
    .birth_mask_i(bm), .survive_mask_i(sm), .update_i(upd), .update_val_i(uval),
    .data_o(d2), .gen_o(g2), .stable_o(s2), .age_o(a2));

  bsg_cgol_row #(.width_p(8), .gen_width_p(16), .wrap_p(0), .age_width_p(2)) u_age2 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .north_i(north), .south_i(south),
    .birth_mask_i(bm), .survive_mask_i(sm), .update_i(upd), .update_val_i(uval),
    .data_o(d3), .gen_o(g3), .stable_o(s3), .age_o(a3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] block_age(input int steps);
    logic [15:0] r;
    logic [1:0]  a;
    r = '0;
`ifdef BSG_CGOL_AGE_EN
    a = (steps > 3) ? 2'd3 : 2'(steps);
    r[7:6] = a;
    r[9:8] = a;
`else
    a = 2'(steps);
    r = {14'd0, a & 2'd0};
`endif
    return r;
  endfunction

  initial begin
    // Reset dominates simultaneous step and load
    rst = 1'b1; en = 1'b1; upd = 1'b1; uval = 8'hFF;
    north = 8'hFF; south = 8'hFF; bm = 9'h008; sm = 9'h00C;
    tick(); tick();
    rst = 1'b0; en = 1'b0; upd = 1'b0;
    chk("rst_data",   {24'd0, d0}, 32'h0);
    chk("rst_gen",    {16'd0, g0}, 32'h0);
    chk("rst_stable", {31'd0, s0}, 32'h0);
    chk("rst_wrap",   {24'd0, d1}, 32'h0);
    chk("rst_age",    {16'd0, a3}, 32'h0);

    // All-dead step: nothing changes, so stable rises
    north = 8'h00; south = 8'h00; en = 1'b1;
    tick(); en = 1'b0;
    chk("zero_data",   {24'd0, d0}, 32'h0);
    chk("zero_gen",    {16'd0, g0}, 32'h1);
    chk("zero_stable", {31'd0, s0}, 32'h1);

    upd = 1'b1; uval = 8'h1C;
    tick(); upd = 1'b0;
    chk("load_data",   {24'd0, d0}, 32'h1C);
    chk("load_gen",    {16'd0, g0}, 32'h0);
    chk("load_stable", {31'd0, s0}, 32'h0);

    // Blinker middle row
    en = 1'b1;
    tick();
    chk("blink1_data",   {24'd0, d0}, 32'h08);
    chk("blink1_stable", {31'd0, s0}, 32'h0);
    north = 8'h08; south = 8'h08;
    tick(); en = 1'b0;
    chk("blink2_data", {24'd0, d0}, 32'h1C);
    chk("blink2_wrap", {24'd0, d1}, 32'h1C);
    chk("blink_gen",   {16'd0, g0}, 32'h2);
    chk("blink_gen2",  {30'd0, g2}, 32'h2);

    // Hold: masks and neighbours ignored with en low
    north = 8'hFF; bm = 9'h1FF; sm = 9'h000;
    tick();
    chk("hold_data", {24'd0, d0}, 32'h1C);
    chk("hold_gen",  {16'd0, g0}, 32'h2);

    // Edge: S1 only, no neighbours -> ends see each other only when wrapping
    upd = 1'b1; uval = 8'h81;
    tick(); upd = 1'b0;
    bm = 9'h000; sm = 9'h002; north = 8'h00; south = 8'h00; en = 1'b1;
    tick(); en = 1'b0;
    chk("edge_dead_data",   {24'd0, d0}, 32'h00);
    chk("edge_dead_stable", {31'd0, s0}, 32'h0);
    chk("edge_wrap_data",   {24'd0, d1}, 32'h81);
    chk("edge_wrap_stable", {31'd0, s1}, 32'h1);

    // Edge under Conway with north=south=8'h81
    upd = 1'b1; uval = 8'h81;
    tick(); upd = 1'b0;
    bm = 9'h008; sm = 9'h00C; north = 8'h81; south = 8'h81; en = 1'b1;
    tick(); en = 1'b0;
    chk("conway_dead_data", {24'd0, d0}, 32'hC3);
    chk("conway_wrap_data", {24'd0, d1}, 32'h42);

    // Step/load collision: the step wins
    upd = 1'b1; uval = 8'h00;
    tick();
    en = 1'b1; uval = 8'hFF; bm = 9'h000; sm = 9'h000; north = 8'h00; south = 8'h00;
    tick(); en = 1'b0; upd = 1'b0;
    chk("coll_data",   {24'd0, d0}, 32'h00);
    chk("coll_gen",    {16'd0, g0}, 32'h1);
    chk("coll_stable", {31'd0, s0}, 32'h1);

    // 2-bit generation counter wraps
    upd = 1'b1; uval = 8'h00;
    tick(); upd = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("gen2_step%0d", k), {30'd0, g2}, 32'((k + 1) % 4));
    end
    en = 1'b0;
    chk("gen16_after5", {16'd0, g0}, 32'h5);
    upd = 1'b1;
    tick(); upd = 1'b0;
    chk("gen2_load",    {30'd0, g2}, 32'h0);
    chk("gen2_stable",  {31'd0, s2}, 32'h0);

    // Block still life: this row is the lower half, north supplies the upper half
    upd = 1'b1; uval = 8'h18;
    tick(); upd = 1'b0;
    chk("age_load", {16'd0, a3}, {16'd0, block_age(0)});
    north = 8'h18; south = 8'h00; bm = 9'h008; sm = 9'h00C; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("block_data%0d", k), {24'd0, d3}, 32'h18);
      chk($sformatf("block_age%0d", k),  {16'd0, a3}, {16'd0, block_age(k)});
    end
    north = 8'h00;
    tick(); en = 1'b0;
    chk("kill_data", {24'd0, d3}, 32'h00);
    chk("kill_age",  {16'd0, a3}, 32'h0);

    // Reset mid-run clears a live row
    upd = 1'b1; uval = 8'hFF;
    tick();
    chk("pre_rst_data", {24'd0, d1}, 32'hFF);
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; upd = 1'b0;
    chk("midrst_data",   {24'd0, d1}, 32'h0);
    chk("midrst_gen",    {16'd0, g1}, 32'h0);
    chk("midrst_stable", {31'd0, s1}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
